axi_read_arbiter: RTL and testbench

- Shares one downstream AXI4 read port (AR + R channels) between two upstream read masters: M0 = instruction fetch, M1 = data load.
- Sits between the CPU wrapper's two read masters and a single-read-port slave/bridge.
- Grants one master per transaction and holds the grant from AR through the R beat with RLAST, so the CPU can run with one read path.

---
 rtl/axi_read_arbiter.sv | 172 +++++++++++++++++
 tb/tb_axi_read_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_arbiter.sv
// Two-master AXI4 read arbiter. One shared downstream AR/R port, one transaction at a time.
// Optional macro AXI_RD_ARB_RR_EN selects round-robin on ties; when undefined, M1 wins ties.
module axi_read_arbiter #(
    parameter int ID_BITS   = 4,
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32,
    parameter int LEN_BITS  = 4
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    input  logic [ID_BITS-1:0]   ARID_M0,
    input  logic [ADDR_BITS-1:0] ARADDR_M0,
    input  logic [LEN_BITS-1:0]  ARLEN_M0,
    input  logic [2:0]           ARSIZE_M0,
    input  logic [1:0]           ARBURST_M0,
    input  logic                 ARVALID_M0,
    output logic                 ARREADY_M0,
    input  logic [ID_BITS-1:0]   ARID_M1,
    input  logic [ADDR_BITS-1:0] ARADDR_M1,
    input  logic [LEN_BITS-1:0]  ARLEN_M1,
    input  logic [2:0]           ARSIZE_M1,
    input  logic [1:0]           ARBURST_M1,
    input  logic                 ARVALID_M1,
    output logic                 ARREADY_M1,
    output logic [ID_BITS-1:0]   RID_M0,
    output logic [DATA_BITS-1:0] RDATA_M0,
    output logic [1:0]           RRESP_M0,
    output logic                 RLAST_M0,
    output logic                 RVALID_M0,
    input  logic                 RREADY_M0,
    output logic [ID_BITS-1:0]   RID_M1,
    output logic [DATA_BITS-1:0] RDATA_M1,
    output logic [1:0]           RRESP_M1,
    output logic                 RLAST_M1,
    output logic                 RVALID_M1,
    input  logic                 RREADY_M1,
    output logic [ID_BITS:0]     ARID_S,
    output logic [ADDR_BITS-1:0] ARADDR_S,
    output logic [LEN_BITS-1:0]  ARLEN_S,
    output logic [2:0]           ARSIZE_S,
    output logic [1:0]           ARBURST_S,
    output logic                 ARVALID_S,
    input  logic                 ARREADY_S,
    input  logic [ID_BITS:0]     RID_S,
    input  logic [DATA_BITS-1:0] RDATA_S,
    input  logic [1:0]           RRESP_S,
    input  logic                 RLAST_S,
    input  logic                 RVALID_S,
    output logic                 RREADY_S
);

    // state   | meaning
    // ST_IDLE | no grant; arbitrate pending requests (one-cycle bubble)
    // ST_AR   | forward granted master's AR to the slave
    // ST_R    | route R beats to granted master until RLAST handshake
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_gnt;
    logic   r_last_gnt;
    logic   w_any_req;
    logic   w_winner;
    logic   w_ar_fire;
    logic   w_r_done;

    assign w_any_req = ARVALID_M0 | ARVALID_M1;
    assign w_ar_fire = (r_state == ST_AR) && ARVALID_S && ARREADY_S;
    assign w_r_done  = (r_state == ST_R) && RVALID_S && RREADY_S && RLAST_S;

`ifdef AXI_RD_ARB_RR_EN
    assign w_winner = (ARVALID_M0 && ARVALID_M1) ? ~r_last_gnt : ARVALID_M1;

    // Routing is by grant alone, so the grant bit echoed in RID_S is ignored.
    logic w_unused_bits;
    assign w_unused_bits = RID_S[ID_BITS];
`else
    assign w_winner = ARVALID_M1;

    // last_gnt is kept up to date for parity with the round-robin build but not consumed here.
    logic w_unused_bits;
    assign w_unused_bits = RID_S[ID_BITS] ^ r_last_gnt;
`endif

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_state    <= ST_IDLE;
            r_gnt      <= 1'b0;
            r_last_gnt <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_IDLE) && w_any_req) begin
                r_gnt <= w_winner;
            end
            if (w_ar_fire) begin
                r_last_gnt <= r_gnt;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (w_any_req) w_state_nxt = ST_AR;
            ST_AR:   if (w_ar_fire) w_state_nxt = ST_R;
            ST_R:    if (w_r_done)  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ARID_S     = '0;
        ARADDR_S   = '0;
        ARLEN_S    = '0;
        ARSIZE_S   = '0;
        ARBURST_S  = '0;
        ARVALID_S  = 1'b0;
        ARREADY_M0 = 1'b0;
        ARREADY_M1 = 1'b0;
        RREADY_S   = 1'b0;
        RID_M0     = '0;
        RDATA_M0   = '0;
        RRESP_M0   = '0;
        RLAST_M0   = 1'b0;
        RVALID_M0  = 1'b0;
        RID_M1     = '0;
        RDATA_M1   = '0;
        RRESP_M1   = '0;
        RLAST_M1   = 1'b0;
        RVALID_M1  = 1'b0;
        if (r_state == ST_AR) begin
            if (r_gnt) begin
                ARID_S     = {1'b1, ARID_M1};
                ARADDR_S   = ARADDR_M1;
                ARLEN_S    = ARLEN_M1;
                ARSIZE_S   = ARSIZE_M1;
                ARBURST_S  = ARBURST_M1;
                ARVALID_S  = ARVALID_M1;
                ARREADY_M1 = ARREADY_S;
            end else begin
                ARID_S     = {1'b0, ARID_M0};
                ARADDR_S   = ARADDR_M0;
                ARLEN_S    = ARLEN_M0;
                ARSIZE_S   = ARSIZE_M0;
                ARBURST_S  = ARBURST_M0;
                ARVALID_S  = ARVALID_M0;
                ARREADY_M0 = ARREADY_S;
            end
        end else if (r_state == ST_R) begin
            if (r_gnt) begin
                RREADY_S  = RREADY_M1;
                RID_M1    = RID_S[ID_BITS-1:0];
                RDATA_M1  = RDATA_S;
                RRESP_M1  = RRESP_S;
                RLAST_M1  = RLAST_S;
                RVALID_M1 = RVALID_S;
            end else begin
                RREADY_S  = RREADY_M0;
                RID_M0    = RID_S[ID_BITS-1:0];
                RDATA_M0  = RDATA_S;
                RRESP_M0  = RRESP_S;
                RLAST_M0  = RLAST_S;
                RVALID_M0 = RVALID_S;
            end
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: cycle vector table plus a hand-driven burst sequence.
// Expectations follow the AXI_RD_ARB_RR_EN build setting where tie-break outcomes differ.
module tb_axi_read_arbiter;

`ifdef AXI_RD_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    localparam logic [3:0]  ID0   = 4'h0;
    localparam logic [31:0] ADDR0 = 32'h0000_0100;
    localparam logic [3:0]  LEN0  = 4'd0;
    localparam logic [3:0]  ID1   = 4'h5;
    localparam logic [31:0] ADDR1 = 32'h2000_0040;
    localparam logic [3:0]  LEN1  = 4'd3;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        ARVALID_M0, ARVALID_M1, ARREADY_M0, ARREADY_M1;
    logic [3:0]  RID_M0, RID_M1;
    logic [31:0] RDATA_M0, RDATA_M1;
    logic [1:0]  RRESP_M0, RRESP_M1;
    logic        RLAST_M0, RLAST_M1, RVALID_M0, RVALID_M1;
    logic        RREADY_M0, RREADY_M1;
    logic [4:0]  ARID_S;
    logic [31:0] ARADDR_S;
    logic [3:0]  ARLEN_S;
    logic [2:0]  ARSIZE_S;
    logic [1:0]  ARBURST_S;
    logic        ARVALID_S, ARREADY_S;
    logic [4:0]  RID_S;
    logic [31:0] RDATA_S;
    logic        RLAST_S, RVALID_S, RREADY_S;

    axi_read_arbiter dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ARID_M0(ID0), .ARADDR_M0(ADDR0), .ARLEN_M0(LEN0), .ARSIZE_M0(3'd2), .ARBURST_M0(2'b01),
        .ARVALID_M0(ARVALID_M0), .ARREADY_M0(ARREADY_M0),
        .ARID_M1(ID1), .ARADDR_M1(ADDR1), .ARLEN_M1(LEN1), .ARSIZE_M1(3'd2), .ARBURST_M1(2'b01),
        .ARVALID_M1(ARVALID_M1), .ARREADY_M1(ARREADY_M1),
        .RID_M0(RID_M0), .RDATA_M0(RDATA_M0), .RRESP_M0(RRESP_M0), .RLAST_M0(RLAST_M0),
        .RVALID_M0(RVALID_M0), .RREADY_M0(RREADY_M0),
        .RID_M1(RID_M1), .RDATA_M1(RDATA_M1), .RRESP_M1(RRESP_M1), .RLAST_M1(RLAST_M1),
        .RVALID_M1(RVALID_M1), .RREADY_M1(RREADY_M1),
        .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
        .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
        .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(2'b10), .RLAST_S(RLAST_S),
        .RVALID_S(RVALID_S), .RREADY_S(RREADY_S)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic        rstn, av0, av1, ars, rv, rl, rr0, rr1;
        logic [4:0]  rid_s;
        logic [31:0] rdata;
        logic        e_arv;
        logic [4:0]  e_arid;
        logic [31:0] e_addr;
        logic        e_arr0, e_arr1, e_rrs, e_rv0, e_rv1, e_rl0, e_rl1;
        logic [3:0]  e_rid0, e_rid1;
        logic [31:0] e_d0, e_d1;
    } vec_t;

    vec_t vt[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(
        input logic rstn, av0, av1, ars, rv, rl, rr0, rr1,
        input logic [4:0] rid_s, input logic [31:0] rdata,
        input logic e_arv, input logic [4:0] e_arid, input logic [31:0] e_addr,
        input logic e_arr0, e_arr1, e_rrs, e_rv0, e_rv1, e_rl0, e_rl1,
        input logic [3:0] e_rid0, e_rid1, input logic [31:0] e_d0, e_d1);
        vec_t v;
        v.rstn = rstn; v.av0 = av0; v.av1 = av1; v.ars = ars;
        v.rv = rv; v.rl = rl; v.rr0 = rr0; v.rr1 = rr1;
        v.rid_s = rid_s; v.rdata = rdata;
        v.e_arv = e_arv; v.e_arid = e_arid; v.e_addr = e_addr;
        v.e_arr0 = e_arr0; v.e_arr1 = e_arr1; v.e_rrs = e_rrs;
        v.e_rv0 = e_rv0; v.e_rv1 = e_rv1; v.e_rl0 = e_rl0; v.e_rl1 = e_rl1;
        v.e_rid0 = e_rid0; v.e_rid1 = e_rid1; v.e_d0 = e_d0; v.e_d1 = e_d1;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_vec(input int idx, input vec_t v);
        logic [129:0] act, exp;
        logic [3:0]   e_len;
        ARESETn = v.rstn; ARVALID_M0 = v.av0; ARVALID_M1 = v.av1; ARREADY_S = v.ars;
        RVALID_S = v.rv; RLAST_S = v.rl; RREADY_M0 = v.rr0; RREADY_M1 = v.rr1;
        RID_S = v.rid_s; RDATA_S = v.rdata;
        #1;
        e_len = !v.e_arv ? 4'd0 : (v.e_arid[4] ? LEN1 : LEN0);
        act = {ARVALID_S, ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S,
               ARREADY_M0, ARREADY_M1, RREADY_S, RVALID_M0, RVALID_M1, RLAST_M0, RLAST_M1,
               RID_M0, RID_M1, RDATA_M0, RDATA_M1, RRESP_M0, RRESP_M1};
        exp = {v.e_arv, v.e_arid, v.e_addr, e_len, v.e_arv ? 3'd2 : 3'd0, v.e_arv ? 2'b01 : 2'b00,
               v.e_arr0, v.e_arr1, v.e_rrs, v.e_rv0, v.e_rv1, v.e_rl0, v.e_rl1,
               v.e_rid0, v.e_rid1, v.e_d0, v.e_d1,
               v.e_rv0 ? 2'b10 : 2'b00, v.e_rv1 ? 2'b10 : 2'b00};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL vec%0d: got %h expected %h", idx, act, exp);
        end
        @(posedge ACLK);
        #1;
    endtask

    initial begin
        int lat;
        int beats;
        int cyc;
        logic done;

        // rstn av0 av1 ars rv rl rr0 rr1 rid_s rdata | arv arid addr arr0 arr1 rrs rv0 rv1 rl0 rl1 rid0 rid1 d0 d1
        vt.push_back(mk(0,1,0,1,0,0,0,0, 5'h00, 32'h0,        0,5'h00,32'h0, 0,0,0,0,0,0,0, 4'h0,4'h0, 32'h0,32'h0));
        vt.push_back(mk(1,1,0,1,0,0,0,0, 5'h00, 32'h0,        0,5'h00,32'h0, 0,0,0,0,0,0,0, 4'h0,4'h0, 32'h0,32'h0));
        vt.push_back(mk(1,1,0,1,0,0,0,0, 5'h00, 32'h0,        1,5'h00,ADDR0, 1,0,0,0,0,0,0, 4'h0,4'h0, 32'h0,32'h0));
        vt.push_back(mk(1,0,0,0,1,1,1,0, 5'h00, 32'hDEADBEEF, 0,5'h00,32'h0, 0,0,1,1,0,1,0, 4'h0,4'h0, 32'hDEADBEEF,32'h0));
        vt.push_back(mk(1,0,0,0,0,0,0,0, 5'h00, 32'h0,        0,5'h00,32'h0, 0,0,0,0,0,0,0, 4'h0,4'h0, 32'h0,32'h0));
        // contested round 1 with AR backpressure, then 4-beat M1 burst with RREADY 1,0,1,1,1
        vt.push_back(mk(1,1,1,0,0,0,0,0, 5'h00, 32'h0,        0,5'h00,32'h0, 0,0,0,0,0,0,0, 4'h0,4'h0, 32'h0,32'h0));
        for (int k = 0; k < 3; k++)
            vt.push_back(mk(1,1,1,0,0,0,0,0, 5'h00, 32'h0,    1,5'h15,ADDR1, 0,0,0,0,0,0,0, 4'h0,4'h0, 32'h0,32'h0));
        vt.push_back(mk(1,1,1,1,0,0,0,0, 5'h00, 32'h0,        1,5'h15,ADDR1, 0,1,0,0,0,0,0, 4'h0,4'h0, 32'h0,32'h0));
        vt.push_back(mk(1,1,0,0,1,0,1,1, 5'h05, 32'hB000_0000, 0,5'h00,32'h0, 0,0,1,0,1,0,0, 4'h0,4'h5, 32'h0,32'hB000_0000));
        vt.push_back(mk(1,1,0,0,1,0,1,0, 5'h05, 32'hB000_0001, 0,5'h00,32'h0, 0,0,0,0,1,0,0, 4'h0,4'h5, 32'h0,32'hB000_0001));
        vt.push_back(mk(1,1,0,0,1,0,1,1, 5'h05, 32'hB000_0001, 0,5'h00,32'h0, 0,0,1,0,1,0,0, 4'h0,4'h5, 32'h0,32'hB000_0001));
        vt.push_back(mk(1,1,0,0,1,0,1,1, 5'h05, 32'hB000_0002, 0,5'h00,32'h0, 0,0,1,0,1,0,0, 4'h0,4'h5, 32'h0,32'hB000_0002));
        vt.push_back(mk(1,1,0,0,1,1,1,1, 5'h05, 32'hB000_0003, 0,5'h00,32'h0, 0,0,1,0,1,0,1, 4'h0,4'h5, 32'h0,32'hB000_0003));
        // contested round 2: fixed priority keeps M1, round-robin hands over to M0
        vt.push_back(mk(1,1,1,0,0,0,0,0, 5'h00, 32'h0,        0,5'h00,32'h0, 0,0,0,0,0,0,0, 4'h0,4'h0, 32'h0,32'h0));
        vt.push_back(mk(1,1,1,1,0,0,0,0, 5'h00, 32'h0,        1, RR ? 5'h00 : 5'h15, RR ? ADDR0 : ADDR1,
                        RR, !RR, 0,0,0,0,0, 4'h0,4'h0, 32'h0,32'h0));
        vt.push_back(mk(1,1,0,0,1,1,1,1, RR ? 5'h00 : 5'h15, 32'hC000_0000, 0,5'h00,32'h0,
                        0,0,1, RR, !RR, RR, !RR, 4'h0, RR ? 4'h0 : 4'h5,
                        RR ? 32'hC000_0000 : 32'h0, RR ? 32'h0 : 32'hC000_0000));
        // contested round 3: M1 in both builds
        vt.push_back(mk(1,1,1,0,0,0,0,0, 5'h00, 32'h0,        0,5'h00,32'h0, 0,0,0,0,0,0,0, 4'h0,4'h0, 32'h0,32'h0));
        vt.push_back(mk(1,1,1,1,0,0,0,0, 5'h00, 32'h0,        1,5'h15,ADDR1, 0,1,0,0,0,0,0, 4'h0,4'h0, 32'h0,32'h0));
        vt.push_back(mk(1,1,0,0,1,1,1,1, 5'h15, 32'hC000_0001, 0,5'h00,32'h0, 0,0,1,0,1,0,1, 4'h0,4'h5, 32'h0,32'hC000_0001));
        // M0 read interrupted by reset while in R
        vt.push_back(mk(1,1,0,1,0,0,0,0, 5'h00, 32'h0,        0,5'h00,32'h0, 0,0,0,0,0,0,0, 4'h0,4'h0, 32'h0,32'h0));
        vt.push_back(mk(1,1,0,1,0,0,0,0, 5'h00, 32'h0,        1,5'h00,ADDR0, 1,0,0,0,0,0,0, 4'h0,4'h0, 32'h0,32'h0));
        vt.push_back(mk(1,0,0,0,1,0,1,0, 5'h00, 32'h5555_5555, 0,5'h00,32'h0, 0,0,1,1,0,0,0, 4'h0,4'h0, 32'h5555_5555,32'h0));
        vt.push_back(mk(0,0,0,0,1,0,1,0, 5'h00, 32'h5555_5555, 0,5'h00,32'h0, 0,0,1,1,0,0,0, 4'h0,4'h0, 32'h5555_5555,32'h0));
        vt.push_back(mk(1,0,0,0,1,1,1,0, 5'h00, 32'h5555_5555, 0,5'h00,32'h0, 0,0,0,0,0,0,0, 4'h0,4'h0, 32'h0,32'h0));

        ARESETn = 1'b0; ARVALID_M0 = 0; ARVALID_M1 = 0; ARREADY_S = 0;
        RVALID_S = 0; RLAST_S = 0; RREADY_M0 = 0; RREADY_M1 = 0; RID_S = '0; RDATA_S = '0;
        @(posedge ACLK);
        @(posedge ACLK);
        #1;

        foreach (vt[i]) apply_vec(i, vt[i]);

        // M1 burst: one-cycle AR latency, then exactly 4 beats under irregular RREADY
        ARESETn = 1; ARVALID_M1 = 1; ARREADY_S = 1; RVALID_S = 0; RLAST_S = 0;
        RREADY_M0 = 0; RREADY_M1 = 0; RID_S = 5'h15;
        lat = 0;
        #1;
        while (!(ARVALID_S && ARREADY_S) && lat < 8) begin
            @(posedge ACLK);
            #1;
            lat++;
        end
        check("ar_latency", 64'(lat), 64'd1);
        check("ar_id_m1", 64'(ARID_S), 64'h15);
        @(posedge ACLK);
        #1;
        ARVALID_M1 = 0;
        beats = 0;
        done = 1'b0;
        cyc = 0;
        while (!done && cyc < 40) begin
            RVALID_S  = 1;
            RLAST_S   = (beats == 3);
            RDATA_S   = 32'hA000_0000 + 32'(beats);
            RREADY_M1 = ((cyc % 3) != 1);
            #1;
            if (RVALID_M1 && RREADY_S) begin
                check("burst_data", 64'(RDATA_M1), 64'(32'hA000_0000 + 32'(beats)));
                done = RLAST_M1;
                beats++;
            end
            @(posedge ACLK);
            #1;
            cyc++;
        end
        check("burst_beats", 64'(beats), 64'd4);
        RVALID_S = 1; RLAST_S = 0; RREADY_M1 = 1;
        #1;
        check("post_burst_idle", {61'd0, ARVALID_S, RREADY_S, RVALID_M1}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
